fu_dispatch: RTL and testbench

FU_DISPATCH -- requirements
Module: fu_dispatch

---
 rtl/fu_dispatch.sv | 115 +++++++++++
 tb/tb_fu_dispatch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_dispatch.sv
// Instruction buffer and functional-unit dispatcher with a branch-wait FSM.
// Optional head-blocked stall counter is enabled by defining DISPATCH_PERF_CNT_EN.
package fu_dispatch_pkg;
  typedef enum logic [2:0] {
    FU_NONE, FU_ALU, FU_CTRL_FLOW, FU_LOAD, FU_STORE, FU_CSR, FU_MULT
  } fu_t;

  typedef struct packed {
    fu_t         fu;
    logic [7:0]  operator;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] imm;
    logic [2:0]  trans_id;
    logic [31:0] pc;
    logic        is_compressed;
    logic        branch_predict;
  } dispatch_instr_t;
endpackage

// state       | meaning
// IDLE        | head may dispatch when its unit is ready
// WAIT_BRANCH | a branch is in flight; nothing dispatches until it resolves
module fu_dispatch
  import fu_dispatch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  dispatch_instr_t issue_instr_i,
  output dispatch_instr_t ex_instr_o,
  input  logic [4:0]      fu_ready_i,
  output logic [4:0]      fu_valid_o,
  input  logic            resolve_branch_i,
  output logic [31:0]     stall_cnt_o
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(BUF_DEPTH);

  typedef enum logic {IDLE, WAIT_BRANCH} state_t;

  state_t          state;
  dispatch_instr_t mem [BUF_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            head_valid, full, can_dispatch, push, pop;
  logic [4:0]      unit_sel;

  assign head_valid = (count != '0);
  assign full       = (count == DEPTH_C);
  assign ex_instr_o = head_valid ? mem[rd_ptr] : '0;

  // One-hot unit select {mult,csr,lsu,branch,alu}; NONE selects nothing.
  always_comb begin
    unit_sel = '0;
    case (mem[rd_ptr].fu)
      FU_ALU:            unit_sel = 5'b00001;
      FU_CTRL_FLOW:      unit_sel = 5'b00010;
      FU_LOAD, FU_STORE: unit_sel = 5'b00100;
      FU_CSR:            unit_sel = 5'b01000;
      FU_MULT:           unit_sel = 5'b10000;
      default:           unit_sel = 5'b00000;
    endcase
  end

  assign can_dispatch  = head_valid && (state == IDLE) && !flush_i && !rst_i;
  assign fu_valid_o    = can_dispatch ? (unit_sel & fu_ready_i) : 5'b00000;
  assign pop           = can_dispatch && ((unit_sel == 5'b00000) || |(unit_sel & fu_ready_i));
  assign issue_ready_o = !full && !flush_i && !rst_i;
  assign push          = issue_valid_i && issue_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= issue_instr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        IDLE:        if (pop && mem[rd_ptr].fu == FU_CTRL_FLOW) state <= WAIT_BRANCH;
        WAIT_BRANCH: if (resolve_branch_i) state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Counts flush cycles too: the head was valid and did not leave through dispatch.
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt <= '0;
    else if (head_valid && !pop && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_fu_dispatch.sv
// Scoreboard bench for fu_dispatch: directed scenarios then randomized traffic,
// checked against a queue-based reference model.
module tb_fu_dispatch;
  import fu_dispatch_pkg::*;

  localparam int DEPTH = 2;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, issue_valid_i, issue_ready_o, resolve_branch_i;
  dispatch_instr_t issue_instr_i, ex_instr_o;
  logic [4:0]      fu_ready_i, fu_valid_o;
  logic [31:0]     stall_cnt_o;

  always #5 clk_i = ~clk_i;

  fu_dispatch #(.BUF_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .ex_instr_o(ex_instr_o),
    .fu_ready_i(fu_ready_i), .fu_valid_o(fu_valid_o),
    .resolve_branch_i(resolve_branch_i), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    int              cyc;
    logic [4:0]      fu;
    dispatch_instr_t instr;
  } exp_t;

  exp_t            sb[$];
  exp_t            got;
  dispatch_instr_t model_q[$];
  bit              model_wait;
  logic [31:0]     model_stall;
  int              cyc = 0;
  int              compared = 0, mismatched = 0;
  bit              armed = 0;
  logic            exp_ready;
  dispatch_instr_t exp_ex;
  logic [31:0]     exp_stall;

  function automatic int unit_bit(input fu_t fu);
    case (fu)
      FU_ALU:            return 0;
      FU_CTRL_FLOW:      return 1;
      FU_LOAD, FU_STORE: return 2;
      FU_CSR:            return 3;
      FU_MULT:           return 4;
      default:           return -1;
    endcase
  endfunction

  function automatic dispatch_instr_t mk(input fu_t fu, input logic [2:0] tid);
    dispatch_instr_t i;
    i.fu             = fu;
    i.operator       = 8'($urandom);
    i.operand_a      = $urandom;
    i.operand_b      = $urandom;
    i.imm            = $urandom;
    i.trans_id       = tid;
    i.pc             = $urandom;
    i.is_compressed  = 1'($urandom);
    i.branch_predict = 1'($urandom);
    return i;
  endfunction

  function automatic dispatch_instr_t rand_instr();
    int   r = $urandom_range(0, 15);
    fu_t  f;
    f = (r < 1) ? FU_NONE : (r < 5) ? FU_ALU : (r < 7) ? FU_CTRL_FLOW :
        (r < 9) ? FU_LOAD : (r < 11) ? FU_STORE : (r < 13) ? FU_CSR : FU_MULT;
    return mk(f, 3'($urandom));
  endfunction

  // Drive one cycle of inputs and advance the reference model.
  task automatic step(input logic r, input logic f, input logic v, input dispatch_instr_t ins,
                      input logic [4:0] rdy, input logic res);
    bit popped;
    bit was_wait;
    int b;
    exp_t e;
    @(posedge clk_i); #1;
    rst_i = r; flush_i = f; issue_valid_i = v; issue_instr_i = ins;
    fu_ready_i = rdy; resolve_branch_i = res;
    cyc++;
    exp_ex    = (model_q.size() > 0) ? model_q[0] : '0;
    exp_stall = model_stall;
    popped    = 0;
    was_wait  = model_wait;
    if (r) begin
      exp_ready = 1'b0;
      model_q.delete();
      model_wait  = 0;
      model_stall = '0;
    end else begin
      exp_ready = !f && (model_q.size() < DEPTH);
      if (!f && !was_wait && model_q.size() > 0) begin
        b = unit_bit(model_q[0].fu);
        if (b < 0) popped = 1;
        else if (rdy[b]) begin
          e.cyc = cyc; e.fu = 5'(1 << b); e.instr = model_q[0];
          sb.push_back(e);
          popped = 1;
          if (model_q[0].fu == FU_CTRL_FLOW) model_wait = 1;
        end
      end
      if (was_wait && res) model_wait = 0;
      if (model_q.size() > 0 && !popped && model_stall != 32'hFFFF_FFFF) model_stall++;
      if (popped) void'(model_q.pop_front());
      if (f) begin
        model_q.delete();
        model_wait = 0;
      end else if (v && exp_ready) model_q.push_back(ins);
    end
    armed = (cyc > 1);
  endtask

  task automatic idle(input int n, input logic [4:0] rdy);
    for (int k = 0; k < n; k++) step(0, 0, 0, '0, rdy, 0);
  endtask

  // Monitor: mid-cycle sampling of DUT outputs against the model's expectations.
  initial begin
    logic [31:0] want_stall;
    forever begin
      @(negedge clk_i);
      if (armed) begin
`ifdef DISPATCH_PERF_CNT_EN
        want_stall = exp_stall;
`else
        want_stall = 32'd0;
`endif
        compared++;
        if (issue_ready_o !== exp_ready) begin
          mismatched++;
          $display("FAIL issue_ready cyc=%0d got=%b want=%b", cyc, issue_ready_o, exp_ready);
        end
        compared++;
        if (ex_instr_o !== exp_ex) begin
          mismatched++;
          $display("FAIL ex_instr cyc=%0d got=%h want=%h", cyc, ex_instr_o, exp_ex);
        end
        compared++;
        if (stall_cnt_o !== want_stall) begin
          mismatched++;
          $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", cyc, stall_cnt_o, want_stall);
        end
        if (fu_valid_o !== 5'b00000 || (sb.size() > 0 && sb[0].cyc == cyc)) begin
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL dispatch_unexpected cyc=%0d got=%b want=00000", cyc, fu_valid_o);
          end else begin
            got = sb.pop_front();
            if (got.cyc != cyc || fu_valid_o !== got.fu || ex_instr_o !== got.instr) begin
              mismatched++;
              $display("FAIL dispatch cyc=%0d got fu=%b tid=%0d want cyc=%0d fu=%b tid=%0d",
                       cyc, fu_valid_o, ex_instr_o.trans_id, got.cyc, got.fu, got.instr.trans_id);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1; flush_i = 0; issue_valid_i = 0; issue_instr_i = '0;
    fu_ready_i = '0; resolve_branch_i = 0;
    model_wait = 0; model_stall = '0;

    step(1, 0, 0, '0, 5'b11111, 0);
    step(1, 0, 0, '0, 5'b11111, 0);
    idle(1, 5'b00000);

    // ALU with trans_id 3 and only alu ready
    step(0, 0, 1, mk(FU_ALU, 3'd3), 5'b00001, 0);
    idle(3, 5'b00001);

    // two LOADs back up behind a stalled lsu, then drain in order
    step(0, 0, 1, mk(FU_LOAD, 3'd1), 5'b00000, 0);
    step(0, 0, 1, mk(FU_LOAD, 3'd2), 5'b00000, 0);
    idle(2, 5'b00000);
    idle(3, 5'b00100);

    // branch then ALU: ALU held until the cycle after resolve
    step(0, 0, 1, mk(FU_CTRL_FLOW, 3'd4), 5'b11111, 0);
    step(0, 0, 1, mk(FU_ALU, 3'd5), 5'b11111, 0);
    idle(3, 5'b11111);
    step(0, 0, 0, '0, 5'b11111, 1);
    idle(3, 5'b11111);

    // flush while waiting on a branch with two entries buffered
    step(0, 0, 1, mk(FU_CTRL_FLOW, 3'd6), 5'b11111, 0);
    step(0, 0, 1, mk(FU_ALU, 3'd7), 5'b11111, 0);
    step(0, 0, 1, mk(FU_CSR, 3'd0), 5'b11111, 0);
    step(0, 1, 1, mk(FU_ALU, 3'd1), 5'b11111, 0);
    idle(2, 5'b11111);

    // NONE pops silently; resolve in IDLE is ignored
    step(0, 0, 1, mk(FU_NONE, 3'd2), 5'b00000, 1);
    idle(2, 5'b00000);

    // MULT head blocked for seven cycles
    step(1, 0, 0, '0, 5'b00000, 0);
    step(0, 0, 1, mk(FU_MULT, 3'd3), 5'b00000, 0);
    idle(7, 5'b00000);
    idle(2, 5'b10000);

    // reset with a full buffer and mult ready
    step(0, 0, 1, mk(FU_MULT, 3'd4), 5'b00000, 0);
    step(0, 0, 1, mk(FU_MULT, 3'd5), 5'b00000, 0);
    step(1, 0, 1, mk(FU_ALU, 3'd6), 5'b11111, 0);
    idle(2, 5'b11111);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < 6), rand_instr(), 5'($urandom),
           ($urandom_range(0, 4) == 0));
    end
    idle(4, 5'b11111);

    @(negedge clk_i); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
